// File: rtl/bounce_pkg.sv
// Shared types for the bouncing-box pixel source: axis direction and the 8-entry box palette.
package bounce_pkg;

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_t;

    // Packed so PALETTE[i] selects entry i; colours are 8-bit {R,G,B}, scaled to BPC by the user.
    typedef logic [7:0][23:0] PALETTE_T;

    localparam PALETTE_T PALETTE = {
        24'hFF8000,   // 7 orange
        24'hFFFFFF,   // 6 white
        24'hFF00FF,   // 5 magenta
        24'h00FFFF,   // 4 cyan
        24'hFFFF00,   // 3 yellow
        24'h0000FF,   // 2 blue
        24'h00FF00,   // 1 green
        24'hFF0000    // 0 red
    };

endpackage

// File: rtl/bounce_axis.sv
// One axis of the bouncing box: position, direction and the per-frame bounce decision.
module bounce_axis
    import bounce_pkg::*;
#(
    parameter int LGDIM = 11,
    parameter int BOX   = 64,
    parameter int STEP  = 2,
    parameter int INIT  = 16
) (
    input  logic             i_pixclk,
    input  logic             reset,
    input  logic             i_newframe,
    input  logic [LGDIM-1:0] i_dim,
    output logic [LGDIM-1:0] pos_next,
    output logic             bounce
);

    localparam logic [LGDIM:0]   BOX_X  = (LGDIM+1)'(BOX);
    localparam logic [LGDIM:0]   STEP_X = (LGDIM+1)'(STEP);
    localparam logic [LGDIM-1:0] BOX_L  = LGDIM'(BOX);
    localparam logic [LGDIM-1:0] STEP_L = LGDIM'(STEP);
    localparam logic [LGDIM-1:0] INIT_L = LGDIM'(INIT);

    logic [LGDIM-1:0] pos;
    dir_t             dir, dir_next;

    always_comb begin
        pos_next = pos;
        dir_next = dir;
        bounce   = 1'b0;
        if (reset) begin
            pos_next = INIT_L;
            dir_next = DIR_POS;
        end else if (i_newframe) begin
            if (dir == DIR_POS) begin
                if ({1'b0, pos} + BOX_X + STEP_X >= {1'b0, i_dim}) begin
                    pos_next = i_dim - BOX_L;
                    dir_next = DIR_NEG;
                    bounce   = 1'b1;
                end else begin
                    pos_next = pos + STEP_L;
                end
            end else begin
                if ({1'b0, pos} < STEP_X) begin
                    pos_next = '0;
                    dir_next = DIR_POS;
                    bounce   = 1'b1;
                end else begin
                    pos_next = pos - STEP_L;
                end
            end
        end
    end

    always_ff @(posedge i_pixclk) begin
        pos <= pos_next;
        dir <= dir_next;
    end

endmodule

// File: rtl/bounce_box_src.sv
// Bouncing-box pixel source paced by the HDMI encoder strobes.
// Optional macro BOUNCE_BORDER_EN paints a one-pixel white frame border over everything.
module bounce_box_src
    import bounce_pkg::*;
#(
    parameter int BITS_PER_COLOR = 8,
    parameter int LGDIM          = 11,
    parameter int BOX_W          = 64,
    parameter int BOX_H          = 48,
    parameter int STEP           = 2,
    parameter int INIT_X         = 16,
    parameter int INIT_Y         = 16
) (
    input  logic                        i_pixclk,
    input  logic                        reset,
    input  logic [LGDIM-1:0]            i_width,
    input  logic [LGDIM-1:0]            i_height,
    input  logic                        i_rd,
    input  logic                        i_newline,
    input  logic                        i_newframe,
    output logic [3*BITS_PER_COLOR-1:0] o_pixel
);

    localparam int             BPC   = BITS_PER_COLOR;
    localparam logic [LGDIM-1:0] ONE   = LGDIM'(1);
    localparam logic [LGDIM:0]   ONE_X = (LGDIM+1)'(1);
    localparam logic [LGDIM:0]   BW_X  = (LGDIM+1)'(BOX_W);
    localparam logic [LGDIM:0]   BH_X  = (LGDIM+1)'(BOX_H);

    logic [LGDIM-1:0]   x, y, x_n, y_n, bx_n, by_n;
    logic [2:0]         ci, ci_n;
    logic               bnc_x, bnc_y, in_box;
    logic [23:0]        pal;
    logic [3*BPC-1:0]   pixel_n;

    bounce_axis #(.LGDIM(LGDIM), .BOX(BOX_W), .STEP(STEP), .INIT(INIT_X)) u_axis_x (
        .i_pixclk   (i_pixclk),
        .reset      (reset),
        .i_newframe (i_newframe),
        .i_dim      (i_width),
        .pos_next   (bx_n),
        .bounce     (bnc_x)
    );

    bounce_axis #(.LGDIM(LGDIM), .BOX(BOX_H), .STEP(STEP), .INIT(INIT_Y)) u_axis_y (
        .i_pixclk   (i_pixclk),
        .reset      (reset),
        .i_newframe (i_newframe),
        .i_dim      (i_height),
        .pos_next   (by_n),
        .bounce     (bnc_y)
    );

    always_comb begin
        x_n = x;
        y_n = y;
        if (reset || i_newframe) begin
            x_n = '0;
            y_n = '0;
        end else if (i_newline) begin
            x_n = '0;
            y_n = ({1'b0, y} + ONE_X >= {1'b0, i_height}) ? i_height - ONE : y + ONE;
        end else if (i_rd) begin
            x_n = ({1'b0, x} + ONE_X >= {1'b0, i_width}) ? i_width - ONE : x + ONE;
        end
    end

    // A corner hit raises both bounce flags but advances the palette only once.
    assign ci_n = reset ? '0 : ci + {2'b00, bnc_x | bnc_y};

    // Colour is built from next-state values so the registered output lines up with the counters.
    always_comb begin
        in_box = ({1'b0, x_n} >= {1'b0, bx_n}) && ({1'b0, x_n} < {1'b0, bx_n} + BW_X) &&
                 ({1'b0, y_n} >= {1'b0, by_n}) && ({1'b0, y_n} < {1'b0, by_n} + BH_X);
        pal     = PALETTE[ci_n];
        pixel_n = '0;
        pixel_n[BPC-1:0] = y_n[LGDIM-1 -: BPC];
        if (in_box) begin
            for (int unsigned i = 0; i < BPC; i++) begin
                pixel_n[3*BPC-1-i] = pal[23 - (i % 8)];
                pixel_n[2*BPC-1-i] = pal[15 - (i % 8)];
                pixel_n[BPC-1-i]   = pal[7 - (i % 8)];
            end
        end
`ifdef BOUNCE_BORDER_EN
        if (x_n == '0 || y_n == '0 || x_n == i_width - ONE || y_n == i_height - ONE)
            pixel_n = '1;
`endif
    end

    always_ff @(posedge i_pixclk) begin
        x       <= x_n;
        y       <= y_n;
        ci      <= ci_n;
        o_pixel <= pixel_n;
    end

endmodule

// File: tb/tb_bounce_box_src.sv
// Scoreboard bench for bounce_box_src: a plain-integer model predicts every pixel, a monitor compares.
module tb_bounce_box_src;

    localparam int BPC    = 8;
    localparam int LGDIM  = 11;
    localparam int BOX_W  = 64;
    localparam int BOX_H  = 48;
    localparam int STEP   = 2;
    localparam int INIT_X = 16;
    localparam int INIT_Y = 16;

    logic             i_pixclk = 1'b0;
    logic             reset = 1'b1;
    logic             i_rd = 1'b0, i_newline = 1'b0, i_newframe = 1'b0;
    logic [LGDIM-1:0] i_width = 11'd640, i_height = 11'd480;
    logic [3*BPC-1:0] o_pixel;

    always #5 i_pixclk = ~i_pixclk;

    bounce_box_src #(
        .BITS_PER_COLOR (BPC),
        .LGDIM          (LGDIM),
        .BOX_W          (BOX_W),
        .BOX_H          (BOX_H),
        .STEP           (STEP),
        .INIT_X         (INIT_X),
        .INIT_Y         (INIT_Y)
    ) dut (
        .i_pixclk   (i_pixclk),
        .reset      (reset),
        .i_width    (i_width),
        .i_height   (i_height),
        .i_rd       (i_rd),
        .i_newline  (i_newline),
        .i_newframe (i_newframe),
        .o_pixel    (o_pixel)
    );

    int mx, my, mbx, mby, mdx, mdy, mci;
    int n_vec = 0, n_bad = 0, n_cyc = 0;
    logic [23:0] exp_q[$];

    function automatic logic [23:0] pal(input int i);
        case (i)
            0: return 24'hFF0000;
            1: return 24'h00FF00;
            2: return 24'h0000FF;
            3: return 24'hFFFF00;
            4: return 24'h00FFFF;
            5: return 24'hFF00FF;
            6: return 24'hFFFFFF;
            default: return 24'hFF8000;
        endcase
    endfunction

    function automatic logic [23:0] expect_px(input int w, input int h);
        logic [23:0] c;
        if (mx >= mbx && mx < mbx + BOX_W && my >= mby && my < mby + BOX_H)
            c = pal(mci);
        else
            c = {16'h0000, 8'((my / 8) % 256)};
`ifdef BOUNCE_BORDER_EN
        if (mx == 0 || my == 0 || mx == w - 1 || my == h - 1) c = 24'hFFFFFF;
`endif
        return c;
    endfunction

    // Apply one cycle of strobes to the model (behavioural: positions are plain integers).
    task automatic model(input bit r, input bit nf, input bit nl, input bit rd);
        int w, h;
        bit b;
        w = int'(i_width);
        h = int'(i_height);
        if (r) begin
            mx = 0; my = 0; mbx = INIT_X; mby = INIT_Y; mdx = 1; mdy = 1; mci = 0;
        end else if (nf) begin
            mx = 0; my = 0; b = 0;
            if (mdx > 0 && mbx + BOX_W + STEP >= w) begin mbx = w - BOX_W; mdx = -1; b = 1; end
            else if (mdx < 0 && mbx < STEP)         begin mbx = 0;         mdx = 1;  b = 1; end
            else mbx = mbx + mdx * STEP;
            if (mdy > 0 && mby + BOX_H + STEP >= h) begin mby = h - BOX_H; mdy = -1; b = 1; end
            else if (mdy < 0 && mby < STEP)         begin mby = 0;         mdy = 1;  b = 1; end
            else mby = mby + mdy * STEP;
            if (b) mci = (mci + 1) % 8;
        end else if (nl) begin
            mx = 0;
            my = (my + 1 > h - 1) ? h - 1 : my + 1;
        end else if (rd) begin
            mx = (mx + 1 > w - 1) ? w - 1 : mx + 1;
        end
        exp_q.push_back(expect_px(w, h));
    endtask

    task automatic step(input bit r, input bit nf, input bit nl, input bit rd);
        reset = r; i_newframe = nf; i_newline = nl; i_rd = rd;
        @(posedge i_pixclk);
        #1;
        model(r, nf, nl, rd);
    endtask

    initial begin : monitor
        logic [23:0] e;
        forever begin
            @(negedge i_pixclk);
            n_cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (o_pixel !== e) begin
                    n_bad++;
                    $display("FAIL pixel cyc=%0d model(x=%0d y=%0d bx=%0d by=%0d ci=%0d) got %h exp %h",
                             n_cyc, mx, my, mbx, mby, mci, o_pixel, e);
                end
            end
        end
    end

    initial begin : stimulus
        repeat (3) step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        repeat (20) step(0, 0, 1, 0);
        repeat (645) step(0, 0, 0, 1);
        // Drive the box into the right edge and beyond, then rescan a line through it.
        repeat (290) step(0, 1, 0, 0);
        repeat (20) step(0, 0, 1, 0);
        repeat (645) step(0, 0, 0, 1);
        step(1, 0, 0, 1);
        step(1, 1, 1, 0);
        step(0, 1, 1, 1);
        step(0, 0, 1, 1);
        repeat (5) step(0, 0, 0, 1);
        // Small screen so bounces (including corners) come often.
        i_width = 11'd100;
        i_height = 11'd80;
        repeat (2) step(1, 0, 0, 0);
        for (int ep = 0; ep < 60; ep++) begin
            int k;
            k = $urandom_range(0, 12);
            for (int j = 0; j < k; j++) step(0, 1, $urandom_range(0, 3) == 0, $urandom_range(0, 1));
            if (ep % 17 == 5) step(1, $urandom_range(0, 1), 1, 1);
            for (int ln = 0; ln < 6; ln++) begin
                int s;
                s = $urandom_range(0, 10);
                for (int j = 0; j < s; j++) step(0, 0, 1, $urandom_range(0, 1));
                for (int j = 0; j < 110; j++) step(0, 0, 0, $urandom_range(0, 99) < 85);
            end
        end
        step(0, 0, 0, 0);
        @(negedge i_pixclk);
        @(negedge i_pixclk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected pixels left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
